// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types, limits and helpers for the round-robin bus arbiter.
package arb_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned WD_W        = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Bits needed to hold an index in 0..n-1 (at least one bit).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Master-side request/data lanes plus the shared slave bus.
// The arbiter takes the 'master' modport (it masters the shared slave bus);
// the surrounding masters and slave take the 'slave' modport.
interface bus_arbiter_rr_if #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
);

  logic [N_MASTERS-1:0]    req;
  logic [N_MASTERS-1:0]    gnt;
  logic                    hrd;
  logic [N_MASTERS*AW-1:0] a_m;
  logic [N_MASTERS*DW-1:0] d_m;
  logic [N_MASTERS-1:0]    we_m;
  logic [N_MASTERS-1:0]    rd_m;
  logic [N_MASTERS*DW-1:0] spo_m;
  logic [N_MASTERS-1:0]    ready_m;
  logic [AW-1:0]           a;
  logic [DW-1:0]           d;
  logic                    we;
  logic                    rd;
  logic [DW-1:0]           spo;
  logic                    ready;
  logic                    irq;

  modport master (
    input  req, a_m, d_m, we_m, rd_m, spo, ready,
    output gnt, hrd, spo_m, ready_m, a, d, we, rd, irq
  );

  modport slave (
    output req, a_m, d_m, we_m, rd_m, spo, ready,
    input  gnt, hrd, spo_m, ready_m, a, d, we, rd, irq
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Rotate-priority picker over the minor masters 1..N_MASTERS-1,
// starting with the first minor after ptr. Bit 0 is never picked.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 4,
  localparam int unsigned OW       = clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [OW-1:0]        ptr,
  output logic [OW-1:0]        idx,
  output logic                 valid
);

  localparam int unsigned M = N_MASTERS - 1;

  // First requesting minor in cyclic order after ptr.
  always_comb begin
    int unsigned cand;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < MAX_MASTERS - 1; k++) begin
      if (k < M) begin
        cand = ((32'(ptr) + k) % M) + 1;
        if (!valid && req[OW'(cand)]) begin
          valid = 1'b1;
          idx   = OW'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-to-1 bus arbiter: master 0 has absolute priority at each arbitration
// point, minors share the bus round-robin, no preemption.
// Optional transfer watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_rr
  import arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned TIMEOUT   = 1024
) (
  input logic               clk,
  input logic               rst,
  bus_arbiter_rr_if.master  bus
);

  localparam int unsigned OW = clog2(N_MASTERS);

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] eff;
  logic [OW-1:0] pick_idx;
  logic          pick_valid;
  logic          timeout_c;

  rr_pick #(.N_MASTERS(N_MASTERS)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Master 0 is the default owner whenever the bus is idle.
  assign eff = (state_q == OWN) ? owner_q : '0;

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= OW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Arbitration in IDLE, hold-until-release in OWN.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.req[0]) begin
          state_d = OWN;
          owner_d = '0;
        end else if (pick_valid) begin
          state_d = OWN;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
        end
      end
      OWN: begin
        if (!bus.req[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, herald and the combinational data-path mux.
  always_comb begin
    bus.gnt     = '0;
    bus.a       = '0;
    bus.d       = '0;
    bus.we      = 1'b0;
    bus.rd      = 1'b0;
    bus.spo_m   = '0;
    bus.ready_m = '0;
    bus.irq     = timeout_c;
    bus.hrd     = (state_q == IDLE) && (|bus.req[N_MASTERS-1:1]) && !bus.req[0];
    for (int i = 0; i < N_MASTERS; i++) begin
      if (eff == OW'(i)) begin
        bus.gnt[i]               = 1'b1;
        bus.a                    = bus.a_m[i*AW +: AW];
        bus.d                    = bus.d_m[i*DW +: DW];
        bus.we                   = bus.we_m[i];
        bus.rd                   = bus.rd_m[i];
        bus.spo_m[i*DW +: DW]    = timeout_c ? '1 : bus.spo;
        bus.ready_m[i]           = bus.ready | timeout_c;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [WD_W-1:0] wd_q;
  logic            wd_run_c;

  assign wd_run_c  = (state_q == OWN) && (bus.we_m[eff] | bus.rd_m[eff]) && !bus.ready;
  assign timeout_c = wd_run_c && (wd_q == WD_W'(TIMEOUT - 1));

  // Stall counter; clears on ready, on a state change and after firing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (wd_run_c && (state_d == OWN) && !timeout_c) begin
      wd_q <= wd_q + WD_W'(1);
    end else begin
      wd_q <= '0;
    end
  end
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  assign unused_timeout = ^WD_W'(TIMEOUT);
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios followed by
// randomized traffic, all compared against a behavioural arbiter model.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_arbiter_rr_if #(.N_MASTERS(N), .AW(AW), .DW(DW)) bus ();

  bus_arbiter_rr #(.N_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model: who owns the bus, where the rotation stands, stall age.
  bit m_own;
  int m_owner;
  int m_ptr;
  int m_cnt;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own   = 1'b0;
    m_owner = 0;
    m_ptr   = N - 1;
    m_cnt   = 0;
  endtask

  function automatic bit timeout_now();
`ifdef ARB_TIMEOUT_EN
    int e;
    e = m_own ? m_owner : 0;
    return m_own && (bus.we_m[e] || bus.rd_m[e]) && !bus.ready && (m_cnt == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  // One clock edge of the arbitration rules, using the inputs present at the edge.
  task automatic model_edge();
    bit to;
    int c;
    if (rst) begin
      model_reset();
    end else if (!m_own) begin
      if (bus.req[0]) begin
        m_own   = 1'b1;
        m_owner = 0;
      end else if (|bus.req[N-1:1]) begin
        c = m_ptr;
        do c = (c >= N - 1) ? 1 : c + 1; while (!bus.req[c]);
        m_own   = 1'b1;
        m_owner = c;
        m_ptr   = c;
      end
    end else begin
      to = timeout_now();
      if (!bus.req[m_owner]) begin
        m_own = 1'b0;
        m_cnt = 0;
      end else if ((bus.we_m[m_owner] || bus.rd_m[m_owner]) && !bus.ready) begin
        m_cnt = to ? 0 : m_cnt + 1;
      end else begin
        m_cnt = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Compare every DUT output against the model's view of the current cycle.
  task automatic check_all(input string tag);
    int e;
    bit to;
    logic [N-1:0]    e_gnt;
    logic [N-1:0]    e_rdy;
    logic [N*DW-1:0] e_spo;
    e     = m_own ? m_owner : 0;
    to    = timeout_now();
    e_gnt = '0;
    e_gnt[e] = 1'b1;
    e_rdy = '0;
    e_rdy[e] = bus.ready | to;
    e_spo = '0;
    e_spo[e*DW +: DW] = to ? {DW{1'b1}} : bus.spo;
    check({tag, ".gnt"},     128'(bus.gnt),     128'(e_gnt));
    check({tag, ".hrd"},     128'(bus.hrd),     128'(!m_own && (|bus.req[N-1:1]) && !bus.req[0]));
    check({tag, ".a"},       128'(bus.a),       128'(bus.a_m[e*AW +: AW]));
    check({tag, ".d"},       128'(bus.d),       128'(bus.d_m[e*DW +: DW]));
    check({tag, ".we"},      128'(bus.we),      128'(bus.we_m[e]));
    check({tag, ".rd"},      128'(bus.rd),      128'(bus.rd_m[e]));
    check({tag, ".spo_m"},   128'(bus.spo_m),   128'(e_spo));
    check({tag, ".ready_m"}, 128'(bus.ready_m), 128'(e_rdy));
    check({tag, ".irq"},     128'(bus.irq),     128'(to));
  endtask

  initial begin
    int exp_order [4];
    logic [N-1:0] exp_gnt;
    exp_order = '{1, 2, 3, 1};

    rst       = 1'b1;
    bus.req   = '0;
    bus.a_m   = '0;
    bus.d_m   = '0;
    bus.we_m  = '0;
    bus.rd_m  = '0;
    bus.spo   = '0;
    bus.ready = 1'b0;
    model_reset();
    tick();
    tick();

    // Reset state.
    rst = 1'b0;
    #1;
    check("reset.gnt", 128'(bus.gnt), 128'(4'b0001));
    check("reset.irq", 128'(bus.irq), 128'(1'b0));
    check_all("reset");

    // Herald: a lone minor request gets one IDLE cycle with hrd, then the grant.
    bus.req = 4'b0100;
    #1;
    check("herald.hrd", 128'(bus.hrd), 128'(1'b1));
    check("herald.gnt_idle", 128'(bus.gnt), 128'(4'b0001));
    check_all("herald.idle");
    tick();
    #1;
    check("herald.gnt", 128'(bus.gnt), 128'(4'b0100));
    check("herald.hrd_off", 128'(bus.hrd), 128'(1'b0));

    // Mux: owner 2 sees slave data and ready, everyone else sees zero.
    bus.a_m[2*AW +: AW] = 32'hA5A5_0002;
    bus.a_m[0*AW +: AW] = 32'h0000_0F00;
    bus.spo   = 32'h1234_5678;
    bus.ready = 1'b1;
    #1;
    check("mux.spo_m", 128'(bus.spo_m), 128'({32'h0, 32'h1234_5678, 32'h0, 32'h0}));
    check("mux.ready_m", 128'(bus.ready_m), 128'(4'b0100));
    check("mux.a", 128'(bus.a), 128'(32'hA5A5_0002));
    bus.a_m[2*AW +: AW] = 32'hDEAD_BEEF;
    #1;
    check("mux.a_track", 128'(bus.a), 128'(32'hDEAD_BEEF));
    check_all("mux");
    tick();
    check_all("mux.hold");

    // Asynchronous reset in the middle of owner 2's tenure.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_async.gnt", 128'(bus.gnt), 128'(4'b0001));
    check("rst_async.irq", 128'(bus.irq), 128'(1'b0));
    check("rst_async.ready_m", 128'(bus.ready_m), 128'(4'b0001));
    tick();
    rst       = 1'b0;
    bus.req   = '0;
    bus.ready = 1'b0;
    #1;
    check_all("rst_async.idle");

    // Priority: master 0 beats all minors, then one IDLE herald cycle, then minor 1.
    bus.req = 4'b1111;
    #1;
    check("prio.hrd_blocked", 128'(bus.hrd), 128'(1'b0));
    tick();
    #1;
    check("prio.owner0", 128'(bus.gnt), 128'(4'b0001));
    check_all("prio.own0");
    bus.req = 4'b1110;
    tick();
    #1;
    check("prio.idle_hrd", 128'(bus.hrd), 128'(1'b1));
    check_all("prio.idle");
    tick();
    #1;
    check("prio.owner1", 128'(bus.gnt), 128'(4'b0010));

    // Round-robin: minors 1..3 all requesting, each released after 3 cycles.
    for (int g = 0; g < 4; g++) begin
      exp_gnt = '0;
      exp_gnt[exp_order[g]] = 1'b1;
      check($sformatf("rr.grant%0d", g), 128'(bus.gnt), 128'(exp_gnt));
      check_all($sformatf("rr.own%0d", g));
      tick();
      tick();
      if (g < 3) begin
        bus.req[exp_order[g]] = 1'b0;
        tick();
        bus.req = 4'b1110;
        #1;
        check($sformatf("rr.hrd%0d", g), 128'(bus.hrd), 128'(1'b1));
        check_all($sformatf("rr.idle%0d", g));
        tick();
        #1;
      end
    end
    bus.req = '0;
    tick();
    #1;
    check_all("rr.done");

    // Watchdog: owner 1 reads from a slave that never answers.
    bus.req   = 4'b0010;
    bus.rd_m  = 4'b0010;
    bus.ready = 1'b0;
    bus.spo   = 32'h0BAD_0BAD;
    tick();
    for (int k = 1; k <= 10; k++) begin
      #1;
`ifdef ARB_TIMEOUT_EN
      check($sformatf("wd.irq%0d", k), 128'(bus.irq), 128'(k == 8));
      check($sformatf("wd.ready%0d", k), 128'(bus.ready_m[1]), 128'(k == 8));
      if (k == 8) check("wd.spo_ones", 128'(bus.spo_m[1*DW +: DW]), 128'(32'hFFFF_FFFF));
`else
      check($sformatf("wd.irq%0d", k), 128'(bus.irq), 128'(1'b0));
`endif
      check_all($sformatf("wd.c%0d", k));
      tick();
    end
    bus.req  = '0;
    bus.rd_m = '0;
    tick();
    #1;
    check_all("wd.release");

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom_range(0, 15));
      bus.a_m   = {$urandom, $urandom, $urandom, $urandom};
      bus.d_m   = {$urandom, $urandom, $urandom, $urandom};
      bus.we_m  = N'($urandom_range(0, 15));
      bus.rd_m  = N'($urandom_range(0, 15));
      bus.spo   = $urandom;
      bus.ready = ($urandom_range(0, 3) == 0);
      #1;
      check_all("rand");
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised N-to-1 bus arbiter between bus masters (CPU as major master 0, DMA/peripheral masters as minors) and the single shared slave bus. It adds three things:
- configurable master count and bus widths;
- round-robin fairness among minor masters, with master 0 keeping absolute priority at each arbitration point;
- an optional transfer watchdog that frees the bus from a hung slave and raises `irq`.

All master-side and slave-side signals are muxed combinationally by the registered owner.

## Interface
- `N_MASTERS`, default 4: number of masters, legal range 2..8. Master 0 is the major master.
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 1024: watchdog limit in cycles, legal range 2..65535. Used only with `ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  N_MASTERS  per-master bus request, level, held for the whole tenure
- `gnt`  out  N_MASTERS  one-hot grant
- `hrd`  out  1  herald to master 0: a minor is about to be granted
- `a_m`  in  N_MASTERS*AW  master addresses, master i at `[i*AW +: AW]`
- `d_m`  in  N_MASTERS*DW  master write data
- `we_m`  in  N_MASTERS  master write strobes
- `rd_m`  in  N_MASTERS  master read strobes
- `spo_m`  out  N_MASTERS*DW  read data per master; zero for non-owners
- `ready_m`  out  N_MASTERS  ready per master; zero for non-owners
- `a`  out  AW  slave address
- `d`  out  DW  slave write data
- `we`  out  1  slave write strobe
- `rd`  out  1  slave read strobe
- `spo`  in  DW  slave read data
- `ready`  in  1  slave ready
- `irq`  out  1  watchdog timeout pulse

## Operation
**State and reset**
- State: `IDLE` or `OWN`, plus an `owner` register of width clog2(N_MASTERS).
- Reset values: state `IDLE`, `owner`=0, `rr_ptr`=N_MASTERS-1, `irq`=0, watchdog count 0.

**Grant and mux**
- The effective grant index is `owner` in `OWN` and 0 in `IDLE`.
- `gnt` is the one-hot of the effective index. Master 0 is therefore granted during `IDLE`, so it starts a transfer when `gnt[0] & !hrd`.
- Mux: `a`/`d`/`we`/`rd` come from the effective master.
- Only the effective master sees `spo` and `ready`. All other `spo_m`/`ready_m` slices are 0.
- `hrd` = `IDLE & |req[N_MASTERS-1:1] & !req[0]`.

**Arbitration in `IDLE`**
- If `req[0]`: go to `OWN` with `owner`=0.
- Else, if any minor requests: pick the first requesting minor after `rr_ptr`, searching cyclically over 1..N_MASTERS-1. Go to `OWN`, set `owner` to that minor and update `rr_ptr` to it.
- Else: stay in `IDLE`.
- `rr_ptr` never points at 0 after its first update.

**Holding and release**
- In `OWN`: stay while `req[owner]` is high. Go to `IDLE` on the first cycle it is low.
- No preemption. Master 0 waits for the current minor's release.
- Minors can be starved only by master 0 re-requesting at every `IDLE` cycle; this is accepted.

## Timing
- Grant latency: `req` sampled high in `IDLE` at edge t → `gnt` high after edge t.
- Release: `req[owner]` sampled low at edge t → `IDLE` after t. The earliest next minor grant is one edge later, so there is always at least one `IDLE` cycle between tenures.
- The data path is purely combinational; it adds zero cycles of latency.
- Reset asserted mid-transfer: outputs return to reset values immediately, and `gnt` falls back to master 0.
- Simultaneous requests in `IDLE`: master 0 always wins over minors.

## Configuration
Macro: `ARB_TIMEOUT_EN`.

When defined:
- A counter runs in `OWN` while `(we|rd) & !ready`. It clears on `ready` or on a state change.
- When the count reaches TIMEOUT-1, for one cycle: `ready_m[owner]`=1, `spo_m` slice = all-ones, and `irq`=1.
- The counter then clears. The master must drop `req`.

When not defined:
- No counter is built and `irq` is tied to 0.

## Structure
- Package `arb_pkg`:
  - state enum `IDLE`/`OWN`;
  - `MAX_MASTERS`=8;
  - the `clog2` helper for owner width.
- Sub-module `rr_pick`: combinational rotate-priority picker.
  - Inputs: request vector, pointer.
  - Outputs: index and valid.
  - Excludes bit 0.

## Test plan
- **Reset:** `rst` pulse mid-`OWN` with owner 2 → `gnt`=4'b0001, `irq`=0, state `IDLE` asynchronously.
- **Priority:** `req`=4'b1111 in `IDLE`.
  - Owner 0 on the next edge.
  - After `req[0]` drops: one `IDLE` cycle with `hrd`=1, then owner 1.
- **Round-robin:** `req`=4'b1110 held, each minor released after 3 cycles → grant order 1,2,3,1.
- **Mux:** owner 2, `spo`=32'h12345678, `ready`=1 → `spo_m[2]`=32'h12345678, `ready_m`=4'b0100, all other slices 0. Also checks that `a` tracks `a_m[2]`.
- **Watchdog** (`ARB_TIMEOUT_EN`, TIMEOUT=8): owner 1, `rd`=1, `ready`=0 → on the 8th cycle `ready_m[1]`=1, `spo_m[1]`=32'hFFFFFFFF, `irq` high for exactly 1 cycle.
- **Herald:** `req`=4'b0100 in `IDLE` → `hrd`=1 for one cycle, then `gnt`=4'b0100.
